// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding and wait-FSM states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam logic [6:0] OP_LOAD = 7'b0000011;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand dependency match against the MEM and WB destinations; purely combinational.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic                  rs_used_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic                  mem_regwen_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_regwen_i,
   output logic                  mem_match_o,
   output logic                  wb_match_o,
   output fwd_sel_e              sel_o
);

   // x0 is hardwired zero, so a write to it never creates a dependency
   always_comb begin
      mem_match_o = mem_regwen_i && (mem_rd_i != '0) && (mem_rd_i == rs_i) && rs_used_i;
      wb_match_o  = wb_regwen_i && (wb_rd_i != '0) && (wb_rd_i == rs_i) && rs_used_i;
      sel_o       = FWD_NONE;
      if (mem_match_o) begin
         sel_o = FWD_MEM;
      end else if (wb_match_o) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, multi-cycle memory wait, branch flush.
// Stall/flush/select outputs are combinational from inputs and FSM state; stall counter is registered.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MEM_LAT    = 1,
   parameter int FWD_EN     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] ex_rs1_i,
   input  logic [REG_ADDR_W-1:0] ex_rs2_i,
   input  logic                  ex_rs1_used_i,
   input  logic                  ex_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  mem_regwen_i,
   input  logic                  wb_regwen_i,
   input  logic                  mem_is_load_i,
   input  logic                  mem_access_i,
   input  logic                  br_taken_ex_i,
   input  logic                  cnt_clr_i,
   output logic [1:0]            asel_o,
   output logic [1:0]            bsel_o,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  stall_ex_o,
   output logic                  stall_mem_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  flush_mem_o,
   output logic                  flush_wb_o,
   output logic [31:0]           stall_cycles_o
);

   localparam bit         LAT_GT1   = (MEM_LAT > 1);
   localparam logic [3:0] WCNT_INIT = LAT_GT1 ? 4'(MEM_LAT - 2) : 4'd0;

   state_e      state_q;
   logic [3:0]  wcnt_q;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic        mem_match_a, wb_match_a, mem_match_b, wb_match_b;
   fwd_sel_e    sel_a, sel_b;
   logic        mem_wait, load_use, br_flush;

   hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .rs_i         (ex_rs1_i),
      .rs_used_i    (ex_rs1_used_i),
      .mem_rd_i     (mem_rd_i),
      .mem_regwen_i (mem_regwen_i),
      .wb_rd_i      (wb_rd_i),
      .wb_regwen_i  (wb_regwen_i),
      .mem_match_o  (mem_match_a),
      .wb_match_o   (wb_match_a),
      .sel_o        (sel_a)
   );

   hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .rs_i         (ex_rs2_i),
      .rs_used_i    (ex_rs2_used_i),
      .mem_rd_i     (mem_rd_i),
      .mem_regwen_i (mem_regwen_i),
      .wb_rd_i      (wb_rd_i),
      .wb_regwen_i  (wb_regwen_i),
      .mem_match_o  (mem_match_b),
      .wb_match_o   (wb_match_b),
      .sel_o        (sel_b)
   );

   // The last WAIT cycle (wcnt==0) releases the stall, giving MEM_LAT-1 stalled cycles per access
   always_comb begin
      mem_wait = 1'b0;
      case (state_q)
         ST_RUN:  mem_wait = mem_access_i && LAT_GT1;
         ST_WAIT: mem_wait = (wcnt_q != 4'd0);
         default: mem_wait = 1'b0;
      endcase
   end

   always_comb begin
      if (FWD_EN != 0) begin
         load_use = (mem_match_a || mem_match_b) && mem_is_load_i;
      end else begin
         load_use = mem_match_a || mem_match_b || wb_match_a || wb_match_b;
      end
      br_flush = br_taken_ex_i && !mem_wait && !load_use;
   end

   always_comb begin
      asel_o      = 2'b00;
      bsel_o      = 2'b00;
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      flush_mem_o = 1'b0;
      flush_wb_o  = 1'b0;
      if (!rst_i) begin
         if (FWD_EN != 0) begin
            asel_o = sel_a;
            bsel_o = sel_b;
         end
         stall_if_o  = mem_wait || load_use;
         stall_id_o  = mem_wait || load_use;
         stall_ex_o  = mem_wait || load_use;
         stall_mem_o = mem_wait;
         flush_wb_o  = mem_wait;
         flush_mem_o = load_use && !mem_wait;
         flush_id_o  = br_flush;
         flush_ex_o  = br_flush;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         wcnt_q  <= 4'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_access_i && LAT_GT1) begin
                  state_q <= ST_WAIT;
                  wcnt_q  <= WCNT_INIT;
               end
            end
            ST_WAIT: begin
               if (wcnt_q != 4'd0) begin
                  wcnt_q <= wcnt_q - 4'd1;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr_i) begin
         stall_cnt_d = 32'd0;
      end else if (stall_if_o) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;

endmodule
